// File: rtl/ctrl_pkg.sv
// ctrl_pkg: states, opcodes and datapath select encodings shared by the multicycle control unit
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps funct3/funct7 to an ALU operation, with overrides for address and compare phases
module alu_dec import ctrl_pkg::*; #(
  parameter int ALUCTRL_W = 3
) (
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 is_rtype,
  input  logic                 force_add,
  input  logic                 force_sub,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal
);
  logic [2:0] enc;
  // overrides win; otherwise decode funct3 and flag encodings the ALU does not implement
  always_comb begin
    enc = force_sub ? ALU_SUB :
          force_add ? ALU_ADD :
          funct3 == 3'b000 ? ((is_rtype && funct7) ? ALU_SUB : ALU_ADD) :
          funct3 == 3'b010 ? ALU_SLT :
          funct3 == 3'b110 ? ALU_OR :
          funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    illegal = !force_sub && !force_add && !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
  end
  assign ALUControl = ALUCTRL_W'(enc);
endmodule

// File: rtl/ctrl_multicycle.sv
// ctrl_multicycle: Moore FSM sequencing fetch/decode/execute/memory/writeback for an RV32I core
module ctrl_multicycle import ctrl_pkg::*; #(
  parameter int ALUCTRL_W   = 3,
  parameter bit EN_BNE      = 1'b1,
  parameter bit TRAP_RESUME = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal_instr
);
  state_t state, state_n;
  logic force_add, force_sub, alu_bad, br_ok, br_take;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  assign force_sub = state == BRANCH;
  assign force_add = !(state inside {EXECR, EXECI, BRANCH});
  assign br_ok = funct3 == 3'b000 || (EN_BNE && funct3 == 3'b001);
  assign br_take = funct3[0] ? ~zero : zero;
  assign ALUControl = rst_n ? alu_ctrl : '0;
  alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .funct3(funct3), .funct7(funct7), .is_rtype(state == EXECR),
    .force_add(force_add), .force_sub(force_sub), .ALUControl(alu_ctrl), .illegal(alu_bad)
  );
  // state register; the trap flag is raised as TRAP is entered and only reset clears it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      illegal_instr <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == TRAP) illegal_instr <= 1'b1;
    end
  // next-state: memory states wait on mem_ready, decode dispatches on opcode, bad encodings trap
  always_comb begin
    state_n = state;
    case (state)
      FETCH:    state_n = mem_ready ? DECODE : FETCH;
      DECODE:   state_n = (op == OP_LW || op == OP_SW) ? MEMADR : op == OP_R ? EXECR :
                          op == OP_I ? EXECI : op == OP_B ? BRANCH : op == OP_JAL ? JAL : TRAP;
      MEMADR:   state_n = op == OP_SW ? MEMWRITE : MEMREAD;
      MEMREAD:  state_n = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_n = mem_ready ? FETCH : MEMWRITE;
      EXECR, EXECI: state_n = alu_bad ? TRAP : ALUWB;
      BRANCH:   state_n = br_ok ? FETCH : TRAP;
      JAL:      state_n = ALUWB;
      TRAP:     state_n = TRAP_RESUME ? FETCH : TRAP;
      default:  state_n = FETCH;
    endcase
  end
  // outputs decoded from the registered state; everything is held at 0 while reset is low
  always_comb begin
    mem_req = 1'b0; AdrSrc = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    ResultSrc = RES_ALUOUT; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_RS2; ImmSrc = IMM_I;
    if (rst_n)
      case (state)
        FETCH:    begin mem_req = 1'b1; IRWrite = mem_ready; PCWrite = mem_ready; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES; end
        DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ImmSrc = IMM_B; end
        MEMADR:   begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ImmSrc = op == OP_SW ? IMM_S : IMM_I; end
        MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
        MEMWB:    begin ResultSrc = RES_DATA; RegWrite = 1'b1; end
        MEMWRITE: begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1; end
        EXECR:    ALUSrcA = SRCA_RS1;
        EXECI:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
        ALUWB:    RegWrite = 1'b1;
        BRANCH:   begin ALUSrcA = SRCA_RS1; PCWrite = br_ok & br_take; end
        JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; PCWrite = 1'b1; ImmSrc = IMM_J; end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_ctrl_multicycle.sv
// tb_ctrl_multicycle: instruction-level schedule model with a per-cycle compare against two configurations
module tb_ctrl_multicycle;
  localparam logic [6:0] L_LW = 7'b0000011, L_SW = 7'b0100011, L_R = 7'b0110011;
  localparam logic [6:0] L_I = 7'b0010011, L_B = 7'b1100011, L_JAL = 7'b1101111;
  typedef struct packed {
    logic rs; logic mr; logic z; logic [6:0] op; logic [2:0] f3; logic f7;
    logic [18:0] exp; logic [18:0] care;
  } cyc_t;
  logic clk = 1'b0, rst_n = 1'b0, funct7 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic mem_req0, adr0, irw0, pcw0, mw0, rw0, ill0, mem_req1, adr1, irw1, pcw1, mw1, rw1, ill1;
  logic [1:0] res0, a0, b0, imm0, res1, a1, b1, imm1;
  logic [2:0] alu0;
  logic [3:0] alu1;
  logic [18:0] act;
  bit sel = 1'b0, run = 1'b0, m_bne, m_res, m_ill;
  int cur = 0, tests = 0, fails = 0;
  logic [6:0] i_op;
  logic [2:0] i_f3;
  logic i_f7;
  cyc_t q[$];
  always #5 clk = ~clk;
  ctrl_multicycle dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req0), .AdrSrc(adr0), .IRWrite(irw0), .PCWrite(pcw0), .MemWrite(mw0), .RegWrite(rw0),
    .ResultSrc(res0), .ALUSrcA(a0), .ALUSrcB(b0), .ImmSrc(imm0), .ALUControl(alu0), .illegal_instr(ill0)
  );
  ctrl_multicycle #(.ALUCTRL_W(4), .EN_BNE(1'b0), .TRAP_RESUME(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req1), .AdrSrc(adr1), .IRWrite(irw1), .PCWrite(pcw1), .MemWrite(mw1), .RegWrite(rw1),
    .ResultSrc(res1), .ALUSrcA(a1), .ALUSrcB(b1), .ImmSrc(imm1), .ALUControl(alu1), .illegal_instr(ill1)
  );
  assign act = sel ? {mem_req1, adr1, irw1, pcw1, mw1, rw1, res1, a1, b1, imm1, alu1, ill1}
                   : {mem_req0, adr0, irw0, pcw0, mw0, rw0, res0, a0, b0, imm0, 1'b0, alu0, ill0};
  function automatic bit rb();
    return 1'($urandom);
  endfunction
  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  // one expected cycle: strobes and the trap flag are always checked, selects given as -1 are free
  task automatic cyc(input bit mr, input bit z, input bit mreq, input bit irw, input bit pcw, input bit mw,
                     input bit rw, input int adr, input int res, input int a, input int b, input int imm, input int alu);
    cyc_t t;
    t.rs = 1'b1; t.mr = mr; t.z = z; t.op = i_op; t.f3 = i_f3; t.f7 = i_f7;
    t.exp = '0; t.care = '0;
    {t.exp[18], t.exp[16:13], t.exp[0]} = {mreq, irw, pcw, mw, rw, m_ill};
    {t.care[18], t.care[16:13], t.care[0]} = '1;
    if (adr >= 0) begin t.exp[17] = adr[0]; t.care[17] = 1'b1; end
    if (res >= 0) begin t.exp[12:11] = res[1:0]; t.care[12:11] = '1; end
    if (a >= 0) begin t.exp[10:9] = a[1:0]; t.care[10:9] = '1; end
    if (b >= 0) begin t.exp[8:7] = b[1:0]; t.care[8:7] = '1; end
    if (imm >= 0) begin t.exp[6:5] = imm[1:0]; t.care[6:5] = '1; end
    if (alu >= 0) begin t.exp[4:1] = alu[3:0]; t.care[4:1] = '1; end
    q.push_back(t);
  endtask
  task automatic rst_cyc(input int n);
    cyc_t t;
    m_ill = 1'b0;
    for (int k = 0; k < n; k++) begin
      t.rs = 1'b0; t.mr = rb(); t.z = rb(); t.op = 7'($urandom); t.f3 = 3'($urandom); t.f7 = rb();
      t.exp = '0; t.care = '1;
      q.push_back(t);
    end
  endtask
  task automatic trap();
    m_ill = 1'b1;
    if (m_res) cyc(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
    else begin
      for (int k = 0; k < 10; k++) cyc(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
      rst_cyc(2);
    end
  endtask
  // expand one instruction into its cycle-by-cycle expectations
  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input bit z,
                       input int fw, input int mw, input bit abort);
    bit ok;
    int alu;
    for (int k = 0; k <= fw; k++) begin
      i_op = 7'($urandom); i_f3 = 3'($urandom); i_f7 = rb();
      cyc(k == fw, rb(), 1, k == fw, k == fw, 0, 0, 0, 2, 0, 2, -1, 0);
    end
    i_op = o; i_f3 = f3; i_f7 = f7;
    cyc(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 1, 1, 2, 0);
    if (o == L_LW || o == L_SW) begin
      cyc(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 2, 1, o == L_SW ? 1 : 0, 0);
      for (int k = 0; k <= mw; k++) begin
        if (abort && k == mw) begin rst_cyc(2); return; end
        cyc(k == mw, rb(), 1, 0, 0, o == L_SW, 0, 1, -1, -1, -1, -1, -1);
      end
      if (o == L_LW) cyc(rb(), rb(), 0, 0, 0, 0, 1, -1, 1, -1, -1, -1, -1);
    end else if (o == L_R || o == L_I) begin
      ok = f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
      alu = f3 == 3'd0 ? ((o == L_R && f7) ? 1 : 0) : f3 == 3'd2 ? 5 : f3 == 3'd6 ? 3 : 2;
      cyc(rb(), rb(), 0, 0, 0, 0, 0, -1, -1, 2, o == L_R ? 0 : 1, o == L_R ? -1 : 0, ok ? alu : -1);
      if (ok) cyc(rb(), rb(), 0, 0, 0, 0, 1, -1, 0, -1, -1, -1, -1);
      else trap();
    end else if (o == L_B) begin
      ok = f3 == 3'd0 || (f3 == 3'd1 && m_bne);
      cyc(rb(), z, 0, 0, ok && (f3 == 3'd0 ? z : !z), 0, 0, -1, 0, 2, 0, -1, 1);
      if (!ok) trap();
    end else if (o == L_JAL) begin
      cyc(rb(), rb(), 0, 0, 1, 0, 0, -1, 0, 1, 2, 3, 0);
      cyc(rb(), rb(), 0, 0, 0, 0, 1, -1, 0, -1, -1, -1, -1);
    end else trap();
  endtask
  task automatic rnd_instr();
    int p, k;
    logic [6:0] o;
    logic [2:0] f3;
    p = $urandom_range(0, 12);
    k = $urandom_range(0, 3);
    o = p < 2 ? L_LW : p < 4 ? L_SW : p < 6 ? L_R : p < 8 ? L_I : p < 10 ? L_B : p < 11 ? L_JAL : 7'($urandom);
    f3 = o == L_B ? 3'(k & 1) : k == 0 ? 3'd0 : k == 1 ? 3'd2 : k == 2 ? 3'd6 : 3'd7;
    if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
    instr(o, f3, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 20) == 0);
  endtask
  task automatic drive();
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n = q[i].rs; mem_ready = q[i].mr; zero = q[i].z; op = q[i].op; funct3 = q[i].f3; funct7 = q[i].f7;
      cur = i; run = 1'b1;
    end
    @(posedge clk);
    #1 run = 1'b0;
    q.delete();
  endtask
  // per-cycle compare of the selected configuration against the schedule
  always @(negedge clk)
    if (run) begin
      tests++;
      if (((act ^ q[cur].exp) & q[cur].care) != '0) begin
        fails++;
        $display("FAIL cycle%0d dut%0d op=%b got=%h want=%h mask=%h", cur, sel, q[cur].op, act, q[cur].exp, q[cur].care);
      end
    end
  initial begin
    int n;
    m_bne = 1'b1; m_res = 1'b0; m_ill = 1'b0;
    rst_cyc(2);
    n = q.size(); instr(L_LW, 3'd2, 1'b0, 1'b0, 0, 2, 1'b0);
    chk("lw_len", q.size() - n, 7);
    chk("lw_memwb_res", int'(q[n+6].exp[12:11]), 1);
    n = q.size(); instr(L_SW, 3'd2, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("sw_len", q.size() - n, 4);
    chk("sw_imm", int'(q[n+2].exp[6:5]), 1);
    n = q.size(); instr(L_B, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("beq_len", q.size() - n, 3);
    chk("beq_pcw", int'(q[n+2].exp[15]), 1);
    chk("beq_alu", int'(q[n+2].exp[4:1]), 1);
    n = q.size(); instr(L_B, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("beq_nt_pcw", int'(q[n+2].exp[15]), 0);
    n = q.size(); instr(L_B, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("bne_pcw", int'(q[n+2].exp[15]), 1);
    n = q.size(); instr(L_R, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("r_len", q.size() - n, 4);
    chk("r_sub", int'(q[n+2].exp[4:1]), 1);
    n = q.size(); instr(L_R, 3'd2, 1'b0, 1'b0, 1, 0, 1'b0);
    chk("r_slt", int'(q[n+3].exp[4:1]), 5);
    n = q.size(); instr(L_I, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("i_add", int'(q[n+2].exp[4:1]), 0);
    n = q.size(); instr(L_JAL, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("jal_len", q.size() - n, 4);
    instr(L_SW, 3'd2, 1'b0, 1'b0, 0, 2, 1'b1);
    n = q.size(); instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("trap_len", q.size() - n, 14);
    instr(L_LW, 3'd2, 1'b0, 1'b0, 1, 1, 1'b0);
    drive();
    rst_cyc(2);
    repeat (150) rnd_instr();
    drive();
    sel = 1'b1; m_bne = 1'b0; m_res = 1'b1;
    rst_cyc(2);
    n = q.size(); instr(L_B, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("bne_off_len", q.size() - n, 4);
    instr(L_R, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (150) rnd_instr();
    drive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_multicycle.md
Name: ctrl_multicycle

Overview:
Multi-cycle control unit for the RV32I core, replacing the single-cycle combinational ctrl decoder. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It drives datapath select and write-enable strobes, and holds in memory states until a memory ready handshake completes. It adds a bne option, an illegal-opcode trap, and an ALUControl width parameter.

Parameters:
ALUCTRL_W, 3, width of ALUControl; values above 3 zero-extend the encodings.
EN_BNE, 1, 1 = funct3 001 on opcode 1100011 is decoded as bne; 0 = it is illegal.
TRAP_RESUME, 0, 1 = TRAP returns to FETCH after one cycle; 0 = TRAP holds until reset.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
op  in  7  instr[6:0], sampled from the IR
funct3  in  3  instr[14:12]
funct7  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
AdrSrc  out  1  0 = PC, 1 = ALUResult register
IRWrite  out  1  IR/oldPC load strobe
PCWrite  out  1  PC load strobe
MemWrite  out  1  store strobe
RegWrite  out  1  register file write strobe
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  sticky trap flag

Behaviour:
- Reset (rst_n=0, asynchronous): state <= FETCH, illegal_instr <= 0. While reset is low, mem_req, IRWrite, PCWrite, MemWrite and RegWrite are forced to 0, and all selects are 0.
- States and transitions: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=add (branch target). Next state by op:
  - 0000011 -> MEMADR; 0100011 -> MEMADR
  - 0110011 -> EXECR; 0010011 -> EXECI
  - 1100011 -> BRANCH; 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=add, ImmSrc=00 for lw or 01 for sw. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held steady until mem_ready, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decoder applied, then ALUWB.
- EXECI: as EXECR but ALUSrcB=01, ImmSrc=00, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00. Then FETCH.
  - PCWrite = zero when funct3=000 (beq).
  - PCWrite = ~zero when funct3=001 and EN_BNE=1 (bne).
  - Any other funct3 goes to TRAP instead, with PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=00, PCWrite=1, ImmSrc=11, then ALUWB.
- TRAP: illegal_instr <= 1 on entry; all strobes 0. Exits to FETCH only if TRAP_RESUME=1. illegal_instr stays set until reset.
- ALU decoder, for R-type and I-type:
  - funct3 000: sub when R-type with funct7=1, otherwise add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
  - any other funct3: TRAP from EXECR/EXECI, no RegWrite
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
- Handshake: mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE. AdrSrc and MemWrite are stable throughout wait states.
- Outputs are decoded from the registered state, plus the funct3/funct7/op/zero/mem_ready qualifiers listed above. No output depends on inputs other than these.
- Reset during MEMREAD or MEMWRITE: strobes drop to 0 immediately; the first cycle after reset release is FETCH.

Decomposition:
- ctrl_pkg holds:
  - the state_t enum
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL)
  - ALUControl encodings
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings
- Sub-module alu_dec (combinational): inputs funct3, funct7, is_rtype, force_add, force_sub; outputs ALUControl and an illegal flag.

Test Plan:
- lw with mem_ready low for 2 cycles in MEMREAD -> states FETCH, DECODE, MEMADR, MEMREAD x3, MEMWB; RegWrite=1 and ResultSrc=01 only in MEMWB; 7 cycles total.
- sw (0100011) with mem_ready=1 -> MEMWRITE=1 for exactly one cycle with AdrSrc=1 and ImmSrc=01 in MEMADR; RegWrite never asserts.
- Branch opcode with zero=1: beq gives PCWrite=1 in BRANCH with ALUControl=001. With zero=0, beq gives PCWrite=0. bne (funct3=001) with zero=0 gives PCWrite=1.
- R-type, funct3=000, funct7=1 -> ALUControl=001 in EXECR. Then funct3=010 -> 101. I-type with funct3=000 and funct7=1 -> 000.
- op=1111111 -> TRAP, illegal_instr=1, no strobes for 10 cycles (TRAP_RESUME=0). With EN_BNE=0, bne -> TRAP.
- Assert rst_n=0 mid-MEMWRITE -> MemWrite and mem_req are 0 within the same cycle. After release, FETCH asserts mem_req=1 and illegal_instr=0.
